// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Opcode and FSM state encodings shared by the alu_mdu block.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SRA   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_NOR   = 4'b0111,
        OP_SLT   = 4'b1000,
        OP_SLTU  = 4'b1001,
        OP_MULTU = 4'b1010,
        OP_DIVU  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : alu_mdu_if                                               |
// | Issue/result bundle between the EX-stage controller and alu_mdu.     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface alu_mdu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) ();
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [SHW-1:0]      shamt;
    logic [OP_W-1:0]     alu_control;
    logic                out_valid;
    logic [WIDTH-1:0]    alu_out;
    logic [WIDTH-1:0]    hi_out;
    logic                zout;

    modport master (
        output in_valid, a, b, shamt, alu_control,
        input  in_ready, out_valid, alu_out, hi_out, zout
    );

    modport slave (
        input  in_valid, a, b, shamt, alu_control,
        output in_ready, out_valid, alu_out, hi_out, zout
    );

endinterface
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_muldiv                                                 |
// | Iterative unsigned shift-add multiply / restoring divide, 1 bit/clk. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             is_div,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  done,
    output logic [WIDTH-1:0]      res_lo,
    output logic [WIDTH-1:0]      res_hi
);
    localparam int              CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;   // high product half / partial remainder
    logic [WIDTH-1:0] r_sh;    // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] r_opd;   // multiplicand / divisor

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;

    assign w_add   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_trial = {r_acc, r_sh[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_opd};

    always_comb begin
        w_acc_nxt = w_add[WIDTH:1];
        w_sh_nxt  = {w_add[0], r_sh[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
            end
        end
    end

    // The final step's result is presented combinationally so the top can
    // register it on the same edge the iteration completes.
    assign done   = r_busy && (r_cnt == C_LAST_ITER);
    assign res_lo = w_sh_nxt;
    assign res_hi = w_acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sh     <= '0;
            r_opd    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_is_div <= is_div;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sh     <= is_div ? a : b;
            r_opd    <= is_div ? b : a;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_mdu                                                    |
// | Registered ALU with iterative MULTU/DIVU and valid/ready issue.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input wire logic clk,
    input wire logic rst_n,
    alu_mdu_if.slave bus
);
    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    logic [WIDTH-1:0] r_hi_out;
    logic             r_zout;

    alu_op_e          w_op;
    logic [SHW-1:0]   w_shamt;
    logic             w_accept;
    logic             w_start;
    logic             w_is_div;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    assign w_op     = alu_op_e'(bus.alu_control);
    assign w_shamt  = bus.shamt;
    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_is_div = (w_op == OP_DIVU);

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        case (w_op)
            OP_AND:  w_lo = bus.a & bus.b;
            OP_OR:   w_lo = bus.a | bus.b;
            OP_ADD:  w_lo = bus.a + bus.b;
            OP_SUB:  w_lo = bus.a - bus.b;
            OP_NOR:  w_lo = ~(bus.a | bus.b);
            OP_SLL:  w_lo = bus.b << w_shamt;
            OP_SRL:  w_lo = bus.b >> w_shamt;
            OP_SRA:  w_lo = $unsigned($signed(bus.b) >>> w_shamt);
            OP_SLT:  w_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_lo = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            // Only reached with b == 0: nonzero divisors go to the sequencer.
            OP_DIVU: begin
                w_lo = '1;
                w_hi = bus.a;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_op == OP_MULTU)) begin
                    w_state_nxt = ST_MUL;
                    w_start     = 1'b1;
                end else if (w_accept && w_is_div && (bus.b != '0)) begin
                    w_state_nxt = ST_DIV;
                    w_start     = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_md_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_hi_out    <= '0;
            r_zout      <= 1'b1;
        end else if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_md_lo;
            r_hi_out    <= w_md_hi;
            r_zout      <= (w_md_lo == '0);
        end else if (w_accept && !w_start) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_lo;
            r_hi_out    <= w_hi;
            r_zout      <= (w_lo == '0);
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_seq_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_is_div),
        .a      (bus.a),
        .b      (bus.b),
        .done   (w_md_done),
        .res_lo (w_md_lo),
        .res_hi (w_md_hi)
    );

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.hi_out    = r_hi_out;
    assign bus.zout      = r_zout;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_mdu                                                 |
// | Directed self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic v);
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        bus.shamt       = sh;
        bus.in_valid    = v;
    endtask

    // Waits for the result of a long op issued at the next edge; pokes
    // in_valid with an ADD while busy, which must be ignored.
    task automatic run_long(output int lat, output int low);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        low = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.out_valid) begin
                lat = cyc;
                break;
            end
            if (!bus.in_ready) low++;
            @(negedge clk);
            bus.alu_control = OP_ADD;
            bus.a = 32'd1;
            bus.b = 32'd1;
            bus.in_valid = (cyc % 3 == 0) && !bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0);
        bus8.in_valid = 1'b0; bus8.alu_control = OP_AND;
        bus8.a = 8'd0; bus8.b = 8'd0; bus8.shamt = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.zout !== 1'b1) begin n_fail++; $display("FAIL rst_hold_zout: got %b want 1", bus.zout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL rst_alu_out: got %h want 0", bus.alu_out); end
        n_checks++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL rst_hi_out: got %h want 0", bus.hi_out); end
        n_checks++; if (bus.zout !== 1'b1) begin n_fail++; $display("FAIL rst_zout: got %b want 1", bus.zout); end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops [13] = '{4'b0010, 4'b0110, 4'b0000, 4'b1000, 4'b1001, 4'b0011, 4'b0001,
                                  4'b0111, 4'b0101, 4'b1111, 4'b1000, 4'b1001, 4'b0100};
        logic [31:0] av  [13] = '{32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F,
                                  32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F,
                                  32'h0000_000F, 32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                  32'h0000_000F};
        logic [31:0] bv  [13] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                  32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                  32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_000F, 32'h0000_000F,
                                  32'hFFFF_FFF0};
        logic [4:0]  shv [13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0,
                                  5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4};
        logic [31:0] exp [13] = '{32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0000, 32'h0000_0000,
                                  32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                                  32'h0FFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
                                  32'hFFFF_FF00};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(ops[i], av[i], bv[i], shv[i], 1'b1);
            @(posedge clk); #1;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sc_valid op=%b: got %b want 1", ops[i], bus.out_valid); end
            n_checks++; if (bus.alu_out !== exp[i]) begin n_fail++; $display("FAIL sc_result op=%b: got %h want %h", ops[i], bus.alu_out, exp[i]); end
            n_checks++; if (bus.zout !== (exp[i] == 32'd0)) begin n_fail++; $display("FAIL sc_zout op=%b: got %b want %b", ops[i], bus.zout, exp[i] == 32'd0); end
            n_checks++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL sc_hi op=%b: got %h want 0", ops[i], bus.hi_out); end
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sc_ready op=%b: got %b want 1", ops[i], bus.in_ready); end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sc_pulse: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.alu_out !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL sc_hold: got %h want ffffff00", bus.alu_out); end
    endtask

    task automatic test_multu();
        int lat, low;
        @(negedge clk);
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1);
        run_long(lat, low);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
        n_checks++; if (low !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", low); end
        n_checks++; if (bus.alu_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_lo: got %h want fffffffe", bus.alu_out); end
        n_checks++; if (bus.hi_out !== 32'd1) begin n_fail++; $display("FAIL mul_hi: got %h want 1", bus.hi_out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_back: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_pulse: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.hi_out !== 32'd1) begin n_fail++; $display("FAIL mul_hold_hi: got %h want 1", bus.hi_out); end
    endtask

    task automatic test_divu();
        int lat, low;
        @(negedge clk);
        drive(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b1);
        run_long(lat, low);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
        n_checks++; if (low !== 32) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 32", low); end
        n_checks++; if (bus.alu_out !== 32'd14) begin n_fail++; $display("FAIL div_quot: got %h want e", bus.alu_out); end
        n_checks++; if (bus.hi_out !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %h want 2", bus.hi_out); end
        n_checks++; if (bus.zout !== 1'b0) begin n_fail++; $display("FAIL div_zout: got %b want 0", bus.zout); end
        @(negedge clk);
        drive(OP_DIVU, 32'd5, 32'd0, 5'd0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL div0_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.alu_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_quot: got %h want ffffffff", bus.alu_out); end
        n_checks++; if (bus.hi_out !== 32'd5) begin n_fail++; $display("FAIL div0_rem: got %h want 5", bus.hi_out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL div0_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat, low;
        @(negedge clk);
        drive(OP_MULTU, 32'd3, 32'd5, 5'd0, 1'b1);
        run_long(lat, low);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_mul_latency: got %0d want 33", lat); end
        n_checks++; if (bus.alu_out !== 32'd15) begin n_fail++; $display("FAIL b2b_mul_lo: got %h want f", bus.alu_out); end
        @(negedge clk);
        drive(OP_SUB, 32'd10, 32'd3, 5'd0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.alu_out !== 32'd7) begin n_fail++; $display("FAIL b2b_sub_result: got %h want 7", bus.alu_out); end
        n_checks++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL b2b_sub_hi: got %h want 0", bus.hi_out); end
    endtask

    task automatic test_reset_abort();
        int stale = 0;
        @(negedge clk);
        drive(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL abort_stale_valid: got %0d pulses want 0", stale); end
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_add_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.alu_out !== 32'd2) begin n_fail++; $display("FAIL abort_add_result: got %h want 2", bus.alu_out); end
    endtask

    task automatic test_width8();
        int lat = 0;
        int low = 0;
        @(negedge clk);
        bus8.alu_control = OP_MULTU; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.shamt = 3'd0;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (bus8.out_valid) begin
                lat = cyc;
                break;
            end
            if (!bus8.in_ready) low++;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL w8_mul_latency: got %0d want 9", lat); end
        n_checks++; if (low !== 8) begin n_fail++; $display("FAIL w8_mul_busy_cycles: got %0d want 8", low); end
        n_checks++; if (bus8.hi_out !== 8'hFE) begin n_fail++; $display("FAIL w8_mul_hi: got %h want fe", bus8.hi_out); end
        n_checks++; if (bus8.alu_out !== 8'h01) begin n_fail++; $display("FAIL w8_mul_lo: got %h want 01", bus8.alu_out); end
        @(negedge clk);
        bus8.alu_control = OP_SLL; bus8.a = 8'h00; bus8.b = 8'h01; bus8.shamt = 3'd7;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL w8_sll_valid: got %b want 1", bus8.out_valid); end
        n_checks++; if (bus8.alu_out !== 8'h80) begin n_fail++; $display("FAIL w8_sll_result: got %h want 80", bus8.alu_out); end
        @(negedge clk);
        bus8.alu_control = OP_DIVU; bus8.a = 8'd200; bus8.b = 8'd9; bus8.shamt = 3'd0;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (bus8.out_valid) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL w8_div_latency: got %0d want 9", lat); end
        n_checks++; if (bus8.alu_out !== 8'd22) begin n_fail++; $display("FAIL w8_div_quot: got %h want 16", bus8.alu_out); end
        n_checks++; if (bus8.hi_out !== 8'd2) begin n_fail++; $display("FAIL w8_div_rem: got %h want 02", bus8.hi_out); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_multu();
        test_divu();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered successor to the 32-bit combinational ALU in the datapath. It provides the existing logic, arithmetic and shift operations plus set-less-than, arithmetic shift right, and iterative unsigned multiply and divide. Operations are issued with a valid/ready handshake and results come back as a registered `out_valid` pulse. The block sits in the EX stage of the multi-cycle CPU, and the controller stalls on `in_ready`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, never overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  WIDTH each  operands.
- `shamt`  in  SHW  shift amount; shifts always act on `b`.
- `alu_control`  in  4  opcode.
- `out_valid`  out  1  one-cycle pulse; `alu_out`, `hi_out` and `zout` are valid in that cycle.
- `alu_out`  out  WIDTH  result (low half for MULTU, quotient for DIVU).
- `hi_out`  out  WIDTH  high product or remainder; 0 for single-cycle ops.
- `zout`  out  1  high when `alu_out == 0`.

## Operation
- Handshake: an op is accepted on a rising edge where `in_valid && in_ready`. `in_valid` is ignored while `in_ready` is low. Operands are captured at acceptance, so inputs may change afterwards.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 NOR
  - 0100 SLL, 0101 SRL, 0011 SRA
  - 1000 SLT (signed, result 0/1), 1001 SLTU (result 0/1)
  - 1010 MULTU, 1011 DIVU
  - Any other code yields `alu_out=0`, `hi_out=0`, `zout=1`, with single-cycle latency.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH, with no overflow flag. MULTU produces a 2·WIDTH product split as {`hi_out`, `alu_out`}.
- DIVU uses restoring division, one quotient bit per cycle.
- Divide by zero: quotient is all ones, remainder is `a`, and the result is produced with single-cycle latency.
- States:
  - IDLE: `in_ready=1`.
  - MUL: shift-add, iteration counter runs 0..WIDTH-1.
  - DIV: shift-subtract, same counter.
  - Transitions: IDLE→MUL on accepted MULTU; IDLE→DIV on accepted DIVU with `b≠0`. All other accepted ops stay in IDLE. MUL/DIV→IDLE when the counter reaches WIDTH-1; `out_valid` pulses on the following cycle.
- Output registers hold their last value between `out_valid` pulses.

## Timing
- Reset (`rst_n` low at an edge): state→IDLE, counter→0. `alu_out`, `hi_out` and `out_valid` go to 0; `zout` goes to 1. `in_ready` reads 1 on the first edge after `rst_n` returns high.
- Reset mid-MUL/DIV aborts the op; no `out_valid` is produced for it.
- Single-cycle ops: accepted at edge N, `out_valid` is high during cycle N+1. Back-to-back issue is allowed every cycle.
- MULTU and DIVU (b≠0): accepted at edge N, `out_valid` is high during cycle N+WIDTH+1. `in_ready` is low from cycle N+1 through N+WIDTH and returns high in the same cycle `out_valid` pulses, so a new op may be accepted at that edge.
- `zout` is registered alongside `alu_out`, never computed combinationally from the outputs.

## Structure
- Package `alu_pkg`:
  - `alu_op_e`: 4-bit opcode enum.
  - `alu_state_e`: IDLE/MUL/DIV.
  - Constant `OP_W = 4`.
- Sub-module `seq_muldiv`, parametrised by `WIDTH`:
  - Holds the shared accumulator/remainder register, the operand shift register and the iteration counter.
  - Interface: `start`, `is_div`, `done`.
- The top level holds the single-cycle datapath, the FSM and the output registers.

## Test plan
(All scenarios use WIDTH=32 unless noted.)
- Reset: hold `rst_n=0` for 2 cycles, then release → `in_ready=1`, `out_valid=0`, `alu_out=0`, `zout=1`.
- Single-cycle sweep, issued back-to-back every cycle with a=0x0000_000F, b=0xFFFF_FFF0:
  - ADD → 0xFFFF_FFFF
  - SUB → 0x0000_001F
  - AND → 0, `zout=1`
  - SLT → 0
  - SLTU → 1
  - SRA of b with shamt=4 → 0xFFFF_FFFF
  - Each result must arrive exactly one cycle after issue.
- MULTU a=0xFFFF_FFFF, b=2 → after 33 cycles `alu_out=0xFFFF_FFFE`, `hi_out=1`. `in_ready` must be low for exactly 32 cycles, and `in_valid` pulses during that window must be ignored.
- DIVU a=100, b=7 → quotient 14, remainder 2 at latency 33. DIVU a=5, b=0 → `alu_out=0xFFFF_FFFF`, `hi_out=5` at latency 1.
- Assert reset at cycle 10 of a MULTU, release, then issue ADD 1+1 → no stale `out_valid`; `alu_out=2` one cycle after the ADD is accepted.
- WIDTH=8 build: MULTU 0xFF×0xFF → `hi_out=0xFE`, `alu_out=0x01` at latency 9. SLL with shamt=7 on b=1 → `alu_out=0x80`.
